// File: rtl/button_event_decoder.sv
// Debounced button level -> 1-cycle PRESS/CLICK/LONG_PRESS/REPEAT/RELEASE pulses plus HELD level.
// Latency: every output registered, one cycle after the sampling edge; no backpressure (free-running events).
// Define BTN_AUTOREPEAT_EN to elaborate the auto-repeat pulses while held past LONG_PRESS.
module button_event_decoder #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic PRESS,
  output logic CLICK,
  output logic LONG_PRESS,
  output logic REPEAT,
  output logic RELEASE,
  output logic HELD
);

  localparam int LONG_CYCLES   = CLOCK_FREQ / 1000 * LONG_MS;
  localparam int REPEAT_CYCLES = CLOCK_FREQ / 1000 * REPEAT_MS;
  localparam int MAX_CYCLES    = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W         = $clog2(MAX_CYCLES + 1);

  if (LONG_CYCLES < 2) begin : g_long_chk
    $error("button_event_decoder: LONG_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d, click_d, long_d, release_d;

`ifdef BTN_AUTOREPEAT_EN
  if (REPEAT_CYCLES < 2) begin : g_repeat_chk
    $error("button_event_decoder: REPEAT_CYCLES must be >= 2");
  end
  logic repeat_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (BTN) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = SHORT;
        end
      end
      SHORT: begin
        // Release is checked first so a release on the threshold edge still counts as a click.
        if (!BTN) begin
          click_d   = 1'b1;
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(LONG_CYCLES - 1)) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = LONG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG: begin
        if (!BTN) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      PRESS      <= 1'b0;
      CLICK      <= 1'b0;
      LONG_PRESS <= 1'b0;
      RELEASE    <= 1'b0;
      HELD       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      PRESS      <= press_d;
      CLICK      <= click_d;
      LONG_PRESS <= long_d;
      RELEASE    <= release_d;
      HELD       <= (state_d != IDLE);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      REPEAT <= 1'b0;
    end else begin
      REPEAT <= repeat_d;
    end
  end
`else
  assign REPEAT = 1'b0;
`endif

endmodule
